cmip_fifo_rr_sched: RTL

Round-robin burst scheduler that drains NCH first-word-fall-through sync FIFOs (`cmip_sync_fifo`, FWFT=1) into one valid/ready output stream. Each grant moves one burst, framed by start-of-frame and end-of-frame flags and tagged with its channel number. The block sits between the per-channel acquisition FIFOs and the shared upstream link packer. It owns all FIFO pops, so no other logic may drive channel FIFO `i_rd`.

---
 rtl/cmip_sched_pkg.sv | 25 ++
 rtl/cmip_rr_arb.sv | 28 ++
 rtl/cmip_fifo_rr_sched.sv | 137 +++++++++++++
 3 files changed

// File: rtl/cmip_sched_pkg.sv
// Shared types and helpers for the round-robin FIFO burst scheduler.
// Holds the scheduler state encoding and the packed used-count slice helper.
package cmip_sched_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StArb  = 2'd1,
    StXfer = 2'd2
  } state_e;

  localparam int unsigned MaxVecW = 4096;
  localparam int unsigned MaxCntW = 32;

  // Caller zero-extends the packed count bus to MaxVecW; cnt_w must stay below MaxCntW.
  function automatic logic [MaxCntW-1:0] used_slice(input logic [MaxVecW-1:0] vec,
                                                     input int unsigned      idx,
                                                     input int unsigned      cnt_w);
    logic [MaxVecW-1:0] sh;
    logic [MaxCntW-1:0] mask;
    sh   = vec >> (idx * cnt_w);
    mask = (MaxCntW'(1) << cnt_w) - MaxCntW'(1);
    return sh[MaxCntW-1:0] & mask;
  endfunction

endpackage

// File: rtl/cmip_rr_arb.sv
// Combinational round-robin arbiter: grants the first requester strictly after ptr,
// searching cyclically.
module cmip_rr_arb #(
  parameter int unsigned NCH     = 4,
  parameter int unsigned CH_WDTH = $clog2(NCH)
) (
  input  logic [NCH-1:0]     req,
  input  logic [CH_WDTH-1:0] ptr,
  output logic               gnt_vld,
  output logic [CH_WDTH-1:0] gnt_idx
);

  always_comb begin
    int idx;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    // Walk from the farthest offset to the nearest so the nearest requester wins last.
    for (int off = int'(NCH); off >= 1; off--) begin
      idx = (int'(ptr) + off) % int'(NCH);
      if (req[idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = CH_WDTH'(idx);
      end
    end
  end

endmodule

// File: rtl/cmip_fifo_rr_sched.sv
// Round-robin burst scheduler draining NCH FWFT FIFOs into one framed valid/ready stream.
// Owns every FIFO pop; outputs are combinational from registered state and FIFO flags.
module cmip_fifo_rr_sched
  import cmip_sched_pkg::*;
#(
  parameter int unsigned NCH       = 4,
  parameter int unsigned DATA_WDTH = 32,
  parameter int unsigned ADDR_WDTH = 9,
  parameter int unsigned BURST_LEN = 16,
  parameter int unsigned CH_WDTH   = $clog2(NCH)
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic                           i_en,
  input  logic                           i_flush,
  input  logic [NCH-1:0]                 i_fifo_empty,
  input  logic [NCH*(ADDR_WDTH+1)-1:0]   i_fifo_used_cnt,
  input  logic [NCH*DATA_WDTH-1:0]       i_fifo_dout,
  output logic [NCH-1:0]                 o_fifo_rd,
  output logic                           o_vld,
  input  logic                           i_rdy,
  output logic [DATA_WDTH-1:0]           o_dat,
  output logic                           o_sof,
  output logic                           o_eof,
  output logic [CH_WDTH-1:0]             o_ch,
  output logic                           o_busy,
  output logic                           o_unfl_err
);

  localparam int unsigned CntW  = ADDR_WDTH + 1;
  localparam int unsigned BeatW = $clog2(BURST_LEN + 1);
  localparam logic [CntW-1:0] BurstCnt = CntW'(BURST_LEN);

  state_e               state_q, state_d;
  logic [CH_WDTH-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CH_WDTH-1:0]   gnt_ch_q, gnt_ch_d;
  logic [BeatW-1:0]     beat_q, beat_d;
  logic [BeatW-1:0]     blen_q, blen_d;
  logic                 unfl_q, unfl_d;

  logic [CntW-1:0]      used [NCH];
  logic [NCH-1:0]       req;
  logic                 arb_vld;
  logic [CH_WDTH-1:0]   arb_idx;
  logic [CntW-1:0]      gnt_used;
  logic                 accept;

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    assign used[k] = CntW'(used_slice(MaxVecW'(i_fifo_used_cnt), k, CntW));
    assign req[k]  = (used[k] >= BurstCnt) | (i_flush & ~i_fifo_empty[k]);
  end

  cmip_rr_arb #(
    .NCH     (NCH),
    .CH_WDTH (CH_WDTH)
  ) u_arb (
    .req     (req),
    .ptr     (rr_ptr_q),
    .gnt_vld (arb_vld),
    .gnt_idx (arb_idx)
  );

  assign gnt_used = used[arb_idx];

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    gnt_ch_d  = gnt_ch_q;
    beat_d    = beat_q;
    blen_d    = blen_q;
    unfl_d    = unfl_q;
    o_vld     = 1'b0;
    o_sof     = 1'b0;
    o_eof     = 1'b0;
    o_fifo_rd = '0;
    accept    = 1'b0;
    o_dat     = i_fifo_dout[gnt_ch_q*DATA_WDTH +: DATA_WDTH];

    unique case (state_q)
      StIdle: begin
        if (i_en) state_d = StArb;
      end
      StArb: begin
        if (arb_vld) begin
          gnt_ch_d = arb_idx;
          blen_d   = (gnt_used >= BurstCnt) ? BeatW'(BURST_LEN) : BeatW'(gnt_used);
          beat_d   = '0;
          state_d  = StXfer;
        end else if (!i_en) begin
          state_d = StIdle;
        end
      end
      StXfer: begin
        o_vld  = ~i_fifo_empty[gnt_ch_q];
        o_sof  = o_vld & (beat_q == '0);
        o_eof  = o_vld & (beat_q == blen_q - BeatW'(1));
        accept = o_vld & i_rdy;
        o_fifo_rd[gnt_ch_q] = accept;
        // Starved mid-burst: flag it but keep the burst open until data returns.
        if (i_fifo_empty[gnt_ch_q]) unfl_d = 1'b1;
        if (accept) begin
          if (o_eof) begin
            beat_d   = '0;
            rr_ptr_d = gnt_ch_q;
            state_d  = i_en ? StArb : StIdle;
          end else begin
            beat_d = beat_q + BeatW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= StIdle;
      rr_ptr_q <= CH_WDTH'(NCH - 1);
      gnt_ch_q <= '0;
      beat_q   <= '0;
      blen_q   <= '0;
      unfl_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      gnt_ch_q <= gnt_ch_d;
      beat_q   <= beat_d;
      blen_q   <= blen_d;
      unfl_q   <= unfl_d;
    end
  end

  assign o_ch       = gnt_ch_q;
  assign o_busy     = (state_q != StIdle);
  assign o_unfl_err = unfl_q;

endmodule
